// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM duty-cycle sweep engine: FSM states, sweep modes,
// compare1 register addresses and a small divider helper.
package pwm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WR_LO = 3'd2,
        ST_WR_HI = 3'd3,
        ST_WAIT  = 3'd4
    } sweep_state_t;

    typedef enum logic [1:0] {
        MODE_ONESHOT  = 2'd0,
        MODE_REPEAT   = 2'd1,
        MODE_TRIANGLE = 2'd2,
        MODE_RSVD     = 2'd3
    } sweep_mode_t;

    localparam logic [5:0] CMP1_L_ADDR = 6'h0A;
    localparam logic [5:0] CMP1_H_ADDR = 6'h0B;

    // A divider of zero behaves as one period per step.
    function automatic logic [7:0] eff_div(input logic [7:0] div);
        return (div == 8'd0) ? 8'd1 : div;
    endfunction

endpackage

// File: rtl/sweep_step_calc.sv
// Combinational next-duty computation: clamped step toward stop/start, wrap to start
// in repeat mode and direction reversal at either end in triangle mode.
module sweep_step_calc
    import pwm_pkg::*;
(
    input  logic [15:0] duty,
    input  logic        dir_down,
    input  logic [1:0]  mode,
    input  logic [15:0] start,
    input  logic [15:0] stop,
    input  logic [15:0] step,
    output logic [15:0] next_duty,
    output logic        next_dir_down
);

    logic [16:0] up_sum;
    logic [16:0] dn_diff;
    logic [15:0] up_val;
    logic [15:0] dn_val;

    always_comb begin
        // 17-bit arithmetic so neither direction can wrap past the end points.
        up_sum  = {1'b0, duty} + {1'b0, step};
        dn_diff = {1'b0, duty} - {1'b0, step};
        up_val  = (up_sum > {1'b0, stop}) ? stop : up_sum[15:0];
        dn_val  = (dn_diff[16] || (dn_diff[15:0] < start)) ? start : dn_diff[15:0];

        next_duty     = up_val;
        next_dir_down = 1'b0;
        if (!dir_down) begin
            if (duty >= stop) begin
                if (mode == MODE_TRIANGLE) begin
                    next_duty     = dn_val;
                    next_dir_down = 1'b1;
                end else begin
                    next_duty     = start;
                end
            end
        end else begin
            if (duty <= start) begin
                next_duty     = up_val;
                next_dir_down = 1'b0;
            end else begin
                next_duty     = dn_val;
                next_dir_down = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pwm_sweep_ctrl.sv
// Duty-cycle sweep controller: shares the regs bus between the SPI host path and an
// engine that rewrites compare1 (LSB then MSB) once every sweep_div counter periods.
module pwm_sweep_ctrl
    import pwm_pkg::*;
#(
    parameter logic [5:0] ADDR_CMP1_L = CMP1_L_ADDR,
    parameter logic [5:0] ADDR_CMP1_H = CMP1_H_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        h_read,
    input  logic        h_write,
    input  logic [5:0]  h_addr,
    input  logic [7:0]  h_wdata,
    output logic        r_read,
    output logic        r_write,
    output logic [5:0]  r_addr,
    output logic [7:0]  r_wdata,
    input  logic [15:0] count_val,
    input  logic        sweep_en,
    input  logic [1:0]  sweep_mode,
    input  logic [15:0] sweep_start,
    input  logic [15:0] sweep_stop,
    input  logic [15:0] sweep_step,
    input  logic [7:0]  sweep_div,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [15:0] cur_duty
);

    sweep_state_t state_reg, state_next;

    logic [15:0] duty_reg;
    logic        dir_down_reg;
    logic [7:0]  per_cnt_reg;
    logic [15:0] count_val_q;
    logic        sweep_en_q;
    logic [15:0] start_q, stop_q;
    logic [7:0]  div_q;
    logic [1:0]  mode_q;
    logic [15:0] cur_duty_reg;
    logic        err_reg;

    logic        bus_free;
    logic        tick;
    logic        en_rise;
    logic        cfg_bad;
    logic        step_last;
    logic        one_shot;
    logic        at_stop;
    logic        eng_wr;
    logic [5:0]  eng_addr;
    logic [7:0]  eng_wdata;
    logic [15:0] calc_duty;
    logic        calc_dir_down;

    assign bus_free  = !h_read && !h_write;
    assign tick      = (count_val_q != 16'd0) && (count_val == 16'd0);
    assign en_rise   = sweep_en && !sweep_en_q;
    assign cfg_bad   = (sweep_step == 16'd0) || (sweep_start > sweep_stop);
    assign step_last = ({1'b0, per_cnt_reg} + 9'd1) >= {1'b0, eff_div(div_q)};
    assign one_shot  = (mode_q == MODE_ONESHOT) || (mode_q == MODE_RSVD);
    assign at_stop   = (duty_reg == stop_q);

    sweep_step_calc u_step_calc (
        .duty          (duty_reg),
        .dir_down      (dir_down_reg),
        .mode          (sweep_mode),
        .start         (sweep_start),
        .stop          (sweep_stop),
        .step          (sweep_step),
        .next_duty     (calc_duty),
        .next_dir_down (calc_dir_down)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (en_rise && !cfg_bad) state_next = ST_LOAD;
            ST_LOAD:  state_next = sweep_en ? ST_WR_LO : ST_IDLE;
            ST_WR_LO: begin
                if (!sweep_en)     state_next = ST_IDLE;
                else if (bus_free) state_next = ST_WR_HI;
            end
            // The MSB write completes even when sweep_en has dropped.
            ST_WR_HI: begin
                if (bus_free) begin
                    if (!sweep_en || (one_shot && at_stop)) state_next = ST_IDLE;
                    else                                   state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!sweep_en)              state_next = ST_IDLE;
                else if (tick && step_last) state_next = ST_WR_LO;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        eng_wr    = 1'b0;
        eng_addr  = ADDR_CMP1_L;
        eng_wdata = duty_reg[7:0];
        if (state_reg == ST_WR_LO) begin
            eng_wr = sweep_en && bus_free;
        end else if (state_reg == ST_WR_HI) begin
            eng_wr    = bus_free;
            eng_addr  = ADDR_CMP1_H;
            eng_wdata = duty_reg[15:8];
        end
        r_read   = h_read;
        r_write  = h_write || eng_wr;
        r_addr   = eng_wr ? eng_addr  : h_addr;
        r_wdata  = eng_wr ? eng_wdata : h_wdata;
        busy     = (state_reg != ST_IDLE);
        done     = (state_reg == ST_WR_HI) && bus_free && one_shot && at_stop;
        err      = err_reg;
        cur_duty = cur_duty_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_reg     <= 16'd0;
            dir_down_reg <= 1'b0;
            per_cnt_reg  <= 8'd0;
            count_val_q  <= 16'd0;
            sweep_en_q   <= 1'b0;
            start_q      <= 16'd0;
            stop_q       <= 16'd0;
            div_q        <= 8'd0;
            mode_q       <= 2'd0;
            cur_duty_reg <= 16'd0;
            err_reg      <= 1'b0;
        end else begin
            count_val_q <= count_val;
            sweep_en_q  <= sweep_en;

            if (!sweep_en)
                err_reg <= 1'b0;
            else if ((state_reg == ST_IDLE) && en_rise && cfg_bad)
                err_reg <= 1'b1;

            case (state_reg)
                ST_IDLE: begin
                    if (en_rise) begin
                        start_q <= sweep_start;
                        stop_q  <= sweep_stop;
                        div_q   <= sweep_div;
                        mode_q  <= sweep_mode;
                    end
                end
                ST_LOAD: begin
                    duty_reg     <= start_q;
                    dir_down_reg <= 1'b0;
                    per_cnt_reg  <= 8'd0;
                end
                ST_WR_HI: begin
                    if (bus_free) cur_duty_reg <= duty_reg;
                end
                ST_WAIT: begin
                    if (tick) begin
                        if (step_last) begin
                            duty_reg     <= calc_duty;
                            dir_down_reg <= calc_dir_down;
                            per_cnt_reg  <= 8'd0;
                            start_q      <= sweep_start;
                            stop_q       <= sweep_stop;
                            div_q        <= sweep_div;
                            mode_q       <= sweep_mode;
                        end else begin
                            per_cnt_reg <= per_cnt_reg + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_sweep_ctrl.sv
// Directed bench for pwm_sweep_ctrl: engine write sequences, host priority, abort and
// error handling, asynchronous reset.
module tb_pwm_sweep_ctrl;

    localparam int          PER    = 8;
    localparam logic [5:0]  ADDR_L = 6'h0A;
    localparam logic [5:0]  ADDR_H = 6'h0B;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        h_read = 1'b0, h_write = 1'b0;
    logic [5:0]  h_addr = 6'd0;
    logic [7:0]  h_wdata = 8'd0;
    logic        r_read, r_write;
    logic [5:0]  r_addr;
    logic [7:0]  r_wdata;
    logic [15:0] count_val = 16'd0;
    logic        sweep_en = 1'b0;
    logic [1:0]  sweep_mode = 2'd0;
    logic [15:0] sweep_start = 16'd0, sweep_stop = 16'd0, sweep_step = 16'd0;
    logic [7:0]  sweep_div = 8'd0;
    logic        busy, done, err;
    logic [15:0] cur_duty;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int host_err = 0, seq_err = 0, done_cnt = 0;
    logic [15:0] wq[$];
    int          wcyc[$];
    logic [7:0]  lo_byte;
    logic        lo_pend = 1'b0;

    pwm_sweep_ctrl dut (
        .clk(clk), .rst(rst),
        .h_read(h_read), .h_write(h_write), .h_addr(h_addr), .h_wdata(h_wdata),
        .r_read(r_read), .r_write(r_write), .r_addr(r_addr), .r_wdata(r_wdata),
        .count_val(count_val), .sweep_en(sweep_en), .sweep_mode(sweep_mode),
        .sweep_start(sweep_start), .sweep_stop(sweep_stop), .sweep_step(sweep_step),
        .sweep_div(sweep_div), .busy(busy), .done(done), .err(err), .cur_duty(cur_duty)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            count_val = (count_val == 16'(PER - 1)) ? 16'd0 : count_val + 16'd1;
        end
    end

    // Bus observer: host passthrough, engine LSB/MSB pairing, done pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (r_read != h_read) host_err++;
            if (h_write) begin
                if (!(r_write && r_addr == h_addr && r_wdata == h_wdata)) host_err++;
            end else if (r_write) begin
                if (r_addr == ADDR_L) begin
                    if (lo_pend) seq_err++;
                    lo_byte = r_wdata;
                    lo_pend = 1'b1;
                end else if (r_addr == ADDR_H && lo_pend) begin
                    wq.push_back({r_wdata, lo_byte});
                    wcyc.push_back(cyc);
                    lo_pend = 1'b0;
                end else begin
                    seq_err++;
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            tick_n(1);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_writes(input int cnt, input int max_cyc);
        int n = 0;
        while (wq.size() < cnt && n < max_cyc) begin
            tick_n(1);
            n++;
        end
        check("write_timeout", (wq.size() >= cnt) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic clear_log();
        wq.delete();
        wcyc.delete();
        lo_pend  = 1'b0;
        done_cnt = 0;
        seq_err  = 0;
    endtask

    task automatic config_sweep(input logic [1:0] mode, input logic [15:0] st,
                                input logic [15:0] sp, input logic [15:0] stp,
                                input logic [7:0] dv);
        sweep_mode = mode; sweep_start = st; sweep_stop = sp; sweep_step = stp; sweep_div = dv;
    endtask

    int k;
    int oor;
    logic [15:0] tri_exp [8] = '{16'd0, 16'd25, 16'd50, 16'd60, 16'd35, 16'd10, 16'd0, 16'd25};

    initial begin
        tick_n(3);
        rst = 1'b0;
        tick_n(1);

        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_cur_duty", {16'd0, cur_duty}, 0);
        check("rst_r_write", {31'd0, r_write}, 0);

        // One-shot ramp 100..130 step 10, one write per counter period.
        clear_log();
        config_sweep(2'd0, 16'd100, 16'd130, 16'd10, 8'd1);
        sweep_en = 1'b1;
        tick_n(2);
        wait_idle(400);
        check("t1_count", wq.size(), 4);
        if (wq.size() >= 4) begin
            check("t1_w0", {16'd0, wq[0]}, 100);
            check("t1_w1", {16'd0, wq[1]}, 110);
            check("t1_w2", {16'd0, wq[2]}, 120);
            check("t1_w3", {16'd0, wq[3]}, 130);
            check("t1_gap", wcyc[2] - wcyc[1], PER);
        end
        check("t1_done", done_cnt, 1);
        check("t1_cur_duty", {16'd0, cur_duty}, 130);
        check("t1_seq", seq_err, 0);
        sweep_en = 1'b0;
        tick_n(2);

        // Triangle 0..60 step 25.
        clear_log();
        config_sweep(2'd2, 16'd0, 16'd60, 16'd25, 8'd1);
        sweep_en = 1'b1;
        wait_writes(8, 600);
        sweep_en = 1'b0;
        tick_n(3);
        for (int i = 0; i < 8; i++)
            if (i < wq.size()) check($sformatf("t2_w%0d", i), {16'd0, wq[i]}, {16'd0, tri_exp[i]});
        oor = 0;
        foreach (wq[i]) if (wq[i] > 16'd60) oor++;
        check("t2_range", oor, 0);
        check("t2_done", done_cnt, 0);
        check("t2_busy", {31'd0, busy}, 0);
        check("t2_seq", seq_err, 0);

        // Host write held 5 cycles while engine sits in WR_LO.
        clear_log();
        host_err = 0;
        config_sweep(2'd0, 16'd5, 16'd5, 16'd1, 8'd1);
        sweep_en = 1'b1;
        k = cyc;
        tick_n(2);
        for (int i = 0; i < 5; i++) begin
            h_write = 1'b1;
            h_addr  = 6'(i + 1);
            h_wdata = 8'hA0 + 8'(i);
            tick_n(1);
        end
        h_write = 1'b0;
        wait_idle(100);
        check("t3_count", wq.size(), 1);
        if (wq.size() >= 1) begin
            check("t3_value", {16'd0, wq[0]}, 5);
            check("t3_hi_cycle", wcyc[0] - k, 8);
        end
        check("t3_host", host_err, 0);
        check("t3_done", done_cnt, 1);
        check("t3_seq", seq_err, 0);
        sweep_en = 1'b0;
        tick_n(2);

        // sweep_en drops while the MSB write is stalled by the host.
        clear_log();
        config_sweep(2'd1, 16'd7, 16'd50, 16'd1, 8'd1);
        sweep_en = 1'b1;
        k = cyc;
        tick_n(3);
        h_write = 1'b1; h_addr = 6'h01; h_wdata = 8'h55;
        sweep_en = 1'b0;
        tick_n(1);
        check("t4_busy_stall", {31'd0, busy}, 1);
        check("t4_no_hi_yet", wq.size(), 0);
        tick_n(1);
        h_write = 1'b0;
        tick_n(1);
        check("t4_count", wq.size(), 1);
        if (wq.size() >= 1) begin
            check("t4_value", {16'd0, wq[0]}, 7);
            check("t4_hi_cycle", wcyc[0] - k, 5);
        end
        check("t4_busy_after", {31'd0, busy}, 0);
        check("t4_cur_duty", {16'd0, cur_duty}, 7);
        check("t4_done", done_cnt, 0);
        tick_n(3);
        check("t4_no_more", wq.size(), 1);

        // Bad configurations.
        clear_log();
        config_sweep(2'd0, 16'd0, 16'd10, 16'd0, 8'd1);
        sweep_en = 1'b1;
        tick_n(3);
        check("t5a_err", {31'd0, err}, 1);
        check("t5a_busy", {31'd0, busy}, 0);
        sweep_en = 1'b0;
        tick_n(1);
        check("t5a_err_clr", {31'd0, err}, 0);
        config_sweep(2'd1, 16'd200, 16'd100, 16'd5, 8'd1);
        sweep_en = 1'b1;
        tick_n(3);
        check("t5b_err", {31'd0, err}, 1);
        h_read = 1'b1; h_addr = 6'h03;
        #1;
        check("t5_r_read", {31'd0, r_read}, 1);
        check("t5_r_addr", {26'd0, r_addr}, 3);
        h_read = 1'b0;
        tick_n(2);
        check("t5_no_writes", wq.size(), 0);
        sweep_en = 1'b0;
        tick_n(2);

        // Asynchronous reset during WAIT, then restart from start with div=4.
        clear_log();
        config_sweep(2'd1, 16'd1000, 16'd2000, 16'd100, 8'd4);
        sweep_en = 1'b1;
        wait_writes(1, 100);
        tick_n(3);
        check("t6_pre_cur", {16'd0, cur_duty}, 1000);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy", {31'd0, busy}, 0);
        check("t6_rst_cur", {16'd0, cur_duty}, 0);
        check("t6_rst_err", {31'd0, err}, 0);
        check("t6_rst_wr", {31'd0, r_write}, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_log();
        wait_writes(3, 300);
        if (wq.size() >= 3) begin
            check("t6_w0", {16'd0, wq[0]}, 1000);
            check("t6_w1", {16'd0, wq[1]}, 1100);
            check("t6_w2", {16'd0, wq[2]}, 1200);
            check("t6_gap", wcyc[2] - wcyc[1], 4 * PER);
        end
        sweep_en = 1'b0;
        tick_n(2);
        check("t6_idle", {31'd0, busy}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
